// File: rtl/am_lock_rx.sv
// Alignment-marker lock receiver: finds a lane AM, confirms it one gap later,
// then tracks every expected AM and drops lock after four consecutive misses.
module am_lock_rx #(
    parameter int BLOCK_W = 66,
    parameter int LANE_N  = 4,
    parameter int GAP_N   = 16383
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               valid_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               slip_v_o,
    output logic               lock_v_o,
    output logic [LANE_N-1:0]  lane_o
);

    localparam int CNT_W  = ($clog2(GAP_N + 1) > 14) ? $clog2(GAP_N + 1) : 14;
    localparam int LANE_W = (LANE_N > 1) ? $clog2(LANE_N) : 1;

    // Lane patterns packed as {M6,M5,M4,M2,M1,M0}; up to four lanes are defined.
    localparam logic [47:0] AM_PAT [4] = '{
        48'hB8_89_6F_47_76_90,
        48'h19_3B_0F_E6_C4_F0,
        48'h64_9A_3A_9B_65_C5,
        48'hC2_86_5D_3D_79_A2
    };

    typedef enum logic [2:0] {
        FIND_1ST,
        COUNT_1,
        COMP_2ND,
        LOCKED,
        COUNT_L,
        COMP_L
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         inv_cnt, inv_nxt;
    logic [LANE_W-1:0]  lane_r, lane_nxt;
    logic               slip_nxt, lock_nxt;
    logic [LANE_N-1:0]  lane_o_nxt;

    logic               cand;
    logic [47:0]        am_field;
    logic [LANE_N-1:0]  hit;
    logic [LANE_W-1:0]  found_lane;
    logic               rec_hit;
    logic               unused_bip;

    assign cand       = valid_i && (block_i[BLOCK_W-1 -: 2] == 2'b10);
    assign am_field   = {block_i[55:32], block_i[23:0]};
    assign unused_bip = ^{block_i[63:56], block_i[31:24]};

    always_comb begin
        hit        = '0;
        found_lane = '0;
        for (int i = 0; i < LANE_N; i++) begin
            hit[i] = cand && (am_field == AM_PAT[i[1:0]]);
        end
        for (int i = LANE_N - 1; i >= 0; i--) begin
            if (hit[i]) found_lane = LANE_W'(i);
        end
    end

    assign rec_hit = hit[lane_r];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        inv_nxt   = inv_cnt;
        lane_nxt  = lane_r;
        slip_nxt  = 1'b0;

        if (!valid_i) begin
            // Loss of signal_ok abandons any search or lock silently.
            if (state != FIND_1ST) begin
                state_nxt = FIND_1ST;
                cnt_nxt   = '0;
                inv_nxt   = '0;
            end
        end else begin
            case (state)
                FIND_1ST: begin
                    if (|hit) begin
                        lane_nxt  = found_lane;
                        state_nxt = COUNT_1;
                        cnt_nxt   = CNT_W'(GAP_N);
                    end
                end
                COUNT_1, COUNT_L: begin
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = (state == COUNT_1) ? COMP_2ND : COMP_L;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                COMP_2ND: begin
                    if (rec_hit) begin
                        state_nxt = LOCKED;
                        inv_nxt   = '0;
                    end else begin
                        state_nxt = FIND_1ST;
                        slip_nxt  = 1'b1;
                    end
                end
                LOCKED: begin
                    // This block is already the first of the gap after the confirming AM.
                    if (GAP_N == 1) begin
                        state_nxt = COMP_L;
                    end else begin
                        state_nxt = COUNT_L;
                        cnt_nxt   = CNT_W'(GAP_N - 1);
                    end
                end
                COMP_L: begin
                    if (rec_hit) begin
                        inv_nxt   = '0;
                        state_nxt = COUNT_L;
                        cnt_nxt   = CNT_W'(GAP_N);
                    end else if (inv_cnt == 3'd3) begin
                        inv_nxt   = '0;
                        state_nxt = FIND_1ST;
                        slip_nxt  = 1'b1;
                    end else begin
                        inv_nxt   = inv_cnt + 3'd1;
                        state_nxt = COUNT_L;
                        cnt_nxt   = CNT_W'(GAP_N);
                    end
                end
                default: begin
                    state_nxt = FIND_1ST;
                    cnt_nxt   = '0;
                    inv_nxt   = '0;
                end
            endcase
        end

        lock_nxt   = (state_nxt == LOCKED) || (state_nxt == COUNT_L) || (state_nxt == COMP_L);
        lane_o_nxt = lock_nxt ? (LANE_N'(1) << lane_nxt) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (nreset) begin
            state    <= FIND_1ST;
            cnt      <= '0;
            inv_cnt  <= '0;
            lane_r   <= '0;
            slip_v_o <= 1'b0;
            lock_v_o <= 1'b0;
            lane_o   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            inv_cnt  <= inv_nxt;
            lane_r   <= lane_nxt;
            slip_v_o <= slip_nxt;
            lock_v_o <= lock_nxt;
            lane_o   <= lane_o_nxt;
        end
    end

endmodule

// File: tb/tb_am_lock_rx.sv
// Directed bench for am_lock_rx: a full-gap instance for the long lock/slip
// cases and a short-gap instance for lane sweep, loss of lock, valid drop and reset.
module tb_am_lock_rx;

    localparam int SG = 20;

    typedef struct packed {
        logic       slip;
        logic       lock;
        logic [3:0] lane;
    } obs_t;

    localparam obs_t IDLE = '{slip: 1'b0, lock: 1'b0, lane: 4'b0000};
    localparam obs_t SLIP = '{slip: 1'b1, lock: 1'b0, lane: 4'b0000};

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        v_f = 1'b0, v_s = 1'b0;
    logic [65:0] b_f = '0, b_s = '0;
    logic        slip_f, lock_f, slip_s, lock_s;
    logic [3:0]  lane_f, lane_s;

    obs_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // {M0,M1,M2,M4,M5,M6} per lane
    logic [7:0] pat [4][6] = '{
        '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
        '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
        '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
        '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}
    };

    am_lock_rx dut_full (
        .clk(clk), .nreset(nreset), .valid_i(v_f), .block_i(b_f),
        .slip_v_o(slip_f), .lock_v_o(lock_f), .lane_o(lane_f)
    );

    am_lock_rx #(.GAP_N(SG)) dut (
        .clk(clk), .nreset(nreset), .valid_i(v_s), .block_i(b_s),
        .slip_v_o(slip_s), .lock_v_o(lock_s), .lane_o(lane_s)
    );

    always #5 clk = ~clk;

    function automatic obs_t lk(input int k);
        obs_t o;
        o.slip = 1'b0;
        o.lock = 1'b1;
        o.lane = 4'(1 << k);
        return o;
    endfunction

    function automatic logic [65:0] am(input int k, input logic [1:0] hdr);
        logic [65:0] b;
        b[65:64] = hdr;
        b[7:0]   = pat[k][0];
        b[15:8]  = pat[k][1];
        b[23:16] = pat[k][2];
        b[31:24] = 8'($urandom);
        b[39:32] = pat[k][3];
        b[47:40] = pat[k][4];
        b[55:48] = pat[k][5];
        b[63:56] = 8'($urandom);
        return b;
    endfunction

    function automatic logic [65:0] filler();
        return {2'b01, 32'($urandom), 32'($urandom)};
    endfunction

    task automatic send(input bit full, input logic v, input logic [65:0] blk,
                        input obs_t e, input string tag);
        obs_t got, want;
        if (full) begin
            v_f = v;
            b_f = blk;
        end else begin
            v_s = v;
            b_s = blk;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = full ? {slip_f, lock_f, lane_f} : {slip_s, lock_s, lane_s};
        want = exp_q.pop_front();
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed slip=%b lock=%b lane=%b, expected slip=%b lock=%b lane=%b",
                   tag, got.slip, got.lock, got.lane, want.slip, want.lock, want.lane);
        end
    endtask

    task automatic fill(input bit full, input int n, input obs_t e, input string tag);
        for (int i = 0; i < n; i++) send(full, 1'b1, filler(), e, tag);
    endtask

    task automatic lock_small(input int k);
        send(1'b0, 1'b1, am(k, 2'b10), IDLE, "small_1st_am");
        fill(1'b0, SG, IDLE, "small_count1");
        send(1'b0, 1'b1, am(k, 2'b10), lk(k), "small_lock");
    endtask

    initial begin
        logic [65:0] bad;

        // Reset overrides valid AMs on both instances.
        send(1'b1, 1'b1, am(0, 2'b10), IDLE, "reset_full");
        send(1'b0, 1'b1, am(0, 2'b10), IDLE, "reset_small");
        nreset = 1'b0;
        v_s = 1'b0;

        // Full-gap lane 3 lock with random BIP bytes, hold, then signal loss.
        send(1'b1, 1'b1, am(3, 2'b10), IDLE, "full_1st_am");
        fill(1'b1, 16383, IDLE, "full_count1_no_slip");
        send(1'b1, 1'b1, am(3, 2'b10), lk(3), "full_lock_lane3");
        fill(1'b1, 10, lk(3), "full_lock_hold");
        send(1'b1, 1'b0, filler(), IDLE, "full_drop_valid");

        // Full-gap mismatched second AM: one slip, then idle.
        send(1'b1, 1'b1, am(0, 2'b10), IDLE, "mis_1st_am");
        fill(1'b1, 16383, IDLE, "mis_count1");
        send(1'b1, 1'b1, am(1, 2'b10), SLIP, "mis_2nd_slip");
        send(1'b1, 1'b1, filler(), IDLE, "mis_slip_one_cycle");
        v_f = 1'b0;

        // Lock on every lane with the short gap.
        for (int k = 0; k < 4; k++) begin
            lock_small(k);
            fill(1'b0, 3, lk(k), "lane_hold");
            send(1'b0, 1'b0, filler(), IDLE, "lane_drop");
        end

        // AM one block early is swallowed by the count; the next block is the compare.
        send(1'b0, 1'b1, am(0, 2'b10), IDLE, "early_1st_am");
        fill(1'b0, SG - 1, IDLE, "early_count");
        send(1'b0, 1'b1, am(0, 2'b10), IDLE, "early_am_in_count");
        send(1'b0, 1'b1, filler(), SLIP, "early_comp_slip");
        send(1'b0, 1'b1, filler(), IDLE, "early_slip_one_cycle");

        // Header 01 on an AM is not a candidate.
        send(1'b0, 1'b1, am(0, 2'b01), IDLE, "hdr01_am");
        fill(1'b0, SG, IDLE, "hdr01_gap");
        send(1'b0, 1'b1, am(0, 2'b10), IDLE, "hdr01_not_detected");
        fill(1'b0, SG, IDLE, "hdr01_count");
        send(1'b0, 1'b1, am(0, 2'b10), lk(0), "hdr01_relock");
        send(1'b0, 1'b0, filler(), IDLE, "hdr01_drop");

        // Loss of lock on lane 2.
        lock_small(2);
        for (int j = 0; j < 3; j++) begin
            fill(1'b0, SG, lk(2), "lol_gap");
            bad = am(2, 2'b10);
            if (j == 0) bad = am(3, 2'b10);
            if (j == 1) bad[9] = ~bad[9];
            if (j == 2) bad[65:64] = 2'b01;
            send(1'b0, 1'b1, bad, lk(2), "lol_bad_kept");
        end
        fill(1'b0, SG, lk(2), "lol_gap");
        send(1'b0, 1'b1, am(2, 2'b10), lk(2), "lol_good_clears");
        for (int j = 0; j < 4; j++) begin
            fill(1'b0, SG, lk(2), "lol_gap");
            bad = am(2, 2'b10);
            bad[40] = ~bad[40];
            send(1'b0, 1'b1, bad, (j == 3) ? SLIP : lk(2), (j == 3) ? "lol_lost" : "lol_bad_kept2");
        end
        send(1'b0, 1'b1, filler(), IDLE, "lol_slip_one_cycle");

        // valid_i low during COUNT_1 returns to the search without a slip.
        send(1'b0, 1'b1, am(1, 2'b10), IDLE, "drop_1st_am");
        fill(1'b0, 5, IDLE, "drop_count");
        send(1'b0, 1'b0, filler(), IDLE, "drop_count1");
        fill(1'b0, SG - 6, IDLE, "drop_after");
        send(1'b0, 1'b1, am(1, 2'b10), IDLE, "drop_am_is_first");
        send(1'b0, 1'b1, filler(), IDLE, "drop_no_compare");
        fill(1'b0, SG - 1, IDLE, "drop_recount");
        send(1'b0, 1'b1, am(1, 2'b10), lk(1), "drop_relock");

        // Reset while locked.
        nreset = 1'b1;
        send(1'b0, 1'b1, am(1, 2'b10), IDLE, "reset_locked");
        nreset = 1'b0;
        send(1'b0, 1'b1, filler(), IDLE, "reset_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/am_lock_rx.md
AM_LOCK_RX -- requirements
Module: am_lock_rx

Interface
REQ-001 SHALL have parameter BLOCK_W, default 66: received block width (2-bit sync header plus 64-bit payload).
REQ-002 SHALL have parameter LANE_N, default 4: number of PCS lanes and alignment-marker (AM) patterns.
REQ-003 SHALL have parameter GAP_N, default 16383: number of non-AM blocks between consecutive AMs.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port nreset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port valid_i, input, 1: signal_ok; when 1, block_i holds one received block this cycle.
REQ-007 SHALL have port block_i, input, BLOCK_W: received block; header in [65:64], AM byte Mk in bits [8k+7:8k].
REQ-008 SHALL have port slip_v_o, output, 1: one-cycle pulse requesting a block slip (AM search failed).
REQ-009 SHALL have port lock_v_o, output, 1: AM lock acquired (rx_am_lock).
REQ-010 SHALL have port lane_o, output, LANE_N: one-hot identifier of the locked lane; all zero when not locked.

Function
REQ-011 SHALL detect a candidate AM when all of the following hold: valid_i=1; header = 2'b10; bytes M0,M1,M2,M4,M5,M6 equal a lane pattern. BIP bytes M3 ([31:24]) and M7 ([63:56]) are ignored.
REQ-012 SHALL use these lane patterns (M0,M1,M2 / M4,M5,M6):
- lane0: 90,76,47 / 6F,89,B8
- lane1: F0,C4,E6 / 0F,3B,19
- lane2: C5,65,9B / 3A,9A,64
- lane3: A2,79,3D / 5D,86,C2
REQ-013 SHALL implement states FIND_1ST, COUNT_1, COMP_2ND, LOCKED, COUNT_L, COMP_L.
REQ-014 FIND_1ST: on a candidate AM, record the matching lane and go to COUNT_1. Non-AM blocks leave the state unchanged and SHALL NOT slip.
REQ-015 COUNT_1 and COUNT_L SHALL consume exactly GAP_N valid blocks. They SHALL NOT compare those blocks and SHALL NOT pulse slip. They then go to COMP_2ND or COMP_L respectively.
REQ-016 COMP_2ND: a valid block matching the recorded lane's pattern goes to LOCKED, with lock_v_o=1 and lane_o one-hot from the rising edge that samples it. Any other block pulses slip_v_o for one cycle and returns to FIND_1ST.
REQ-017 LOCKED/COUNT_L/COMP_L: lock_v_o SHALL stay 1. Each expected-AM block is compared against the recorded lane:
- match: clears the invalid counter;
- mismatch: increments it.
REQ-018 When the invalid counter reaches 4 consecutive mismatches, SHALL clear lock_v_o and lane_o, pulse slip_v_o, and return to FIND_1ST.
REQ-019 Cycles with valid_i=0 SHALL NOT advance counters. valid_i=0 while in any state other than FIND_1ST SHALL return to FIND_1ST, clear lock, and produce no slip pulse.
REQ-020 The block counter SHALL be at least 14 bits wide and SHALL reload on every transition into a COUNT state.
REQ-021 Outputs SHALL be registered; slip_v_o SHALL be high for exactly one cycle per slip event.
REQ-022 lane_o SHALL equal 1<<lane while lock_v_o=1, and 0 otherwise.

Reset
REQ-023 With nreset=1 at a rising edge: state becomes FIND_1ST; counters are 0; slip_v_o=0, lock_v_o=0, lane_o=0.
REQ-024 Reset SHALL override all other inputs, including mid-count and when locked.

Verification
REQ-025 Lane-k lock: AM(k), then 16383 random blocks, then AM(k) -> slip_v_o never 1; lock_v_o=1 one edge after the 2nd AM; lane_o=1<<k; lock holds for at least 10 further cycles.
REQ-026 Mismatched 2nd AM: AM(0), 16383 fillers, AM(1) -> single slip_v_o pulse, lock_v_o=0, back in FIND_1ST.
REQ-027 Loss of lock: locked on lane 2, then 3 corrupted AMs and a good one -> lock kept; 4 consecutive corrupted AMs -> lock_v_o=0, lane_o=0, one slip pulse.
REQ-028 BIP bytes don't-care: AMs with random M3/M7 -> lock acquired; header 2'b01 on an AM -> not detected.
REQ-029 valid_i=0 for one cycle during COUNT_1 -> returns to FIND_1ST, no slip; nreset=1 while locked -> all outputs 0 next edge.
